// File: rtl/param_wb_cache.sv
// Direct-mapped write-back / write-allocate cache with req/ack on CPU and memory sides.
// Optional PARAM_WB_CACHE_STATS_EN adds saturating hit/miss/write-back counters.
module param_wb_cache #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef PARAM_WB_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  if (TAG_W < 1) begin : g_bad_tag
    $error("param_wb_cache: TAG_W must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_WB, S_FILL, S_DONE} state_t;

  state_t              state_q;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [OFFSET_W-1:0] off_q, cnt_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic                mem_req_q, mem_we_q, cpu_ready_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, cpu_rdata_q;

  logic [DATA_W-1:0]   data_q [LINES*WORDS];
  logic [TAG_W-1:0]    tags_q [LINES];

  logic                hit, xfer_ack, fill_wr, fill_last, done_go;
  logic [DATA_W-1:0]   load_word;

  assign hit       = valid_q[idx_q] && (tags_q[idx_q] == tag_q);
  assign xfer_ack  = mem_req_q && mem_ack;
  assign fill_wr   = (state_q == S_FILL) && xfer_ack;
  assign fill_last = fill_wr && (&cnt_q);
  assign done_go   = ((state_q == S_TAG) && hit) || fill_last;
  // The last refill word is still on mem_rdata when DONE is entered.
  assign load_word = (fill_wr && (off_q == cnt_q)) ? mem_rdata : data_q[{idx_q, off_q}];

  always_ff @(posedge clk) begin
    if (fill_wr)          data_q[{idx_q, cnt_q}] <= mem_rdata;
    if (done_go && we_q)  data_q[{idx_q, off_q}] <= wdata_q;
    if (fill_last)        tags_q[idx_q]          <= tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cpu_req) begin
          {tag_q, idx_q, off_q} <= cpu_addr;
          we_q    <= cpu_we;
          wdata_q <= cpu_wdata;
          state_q <= S_TAG;
        end
        S_TAG: begin
          cnt_q <= '0;
          if (hit)                 state_q <= S_DONE;
          else if (dirty_q[idx_q]) state_q <= S_WB;
          else                     state_q <= S_FILL;
        end
        S_WB: if (!mem_req_q) begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= {tags_q[idx_q], idx_q, cnt_q};
          mem_wdata_q <= data_q[{idx_q, cnt_q}];
        end else if (mem_ack) begin
          mem_req_q <= 1'b0;
          cnt_q     <= cnt_q + 1'b1;
          if (&cnt_q) begin
            dirty_q[idx_q] <= 1'b0;
            state_q        <= S_FILL;
          end
        end
        S_FILL: if (!mem_req_q) begin
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= {tag_q, idx_q, cnt_q};
        end else if (mem_ack) begin
          mem_req_q <= 1'b0;
          cnt_q     <= cnt_q + 1'b1;
          if (&cnt_q) begin
            valid_q[idx_q] <= 1'b1;
            state_q        <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (done_go) begin
        cpu_ready_q <= 1'b1;
        cpu_rdata_q <= we_q ? wdata_q : load_word;
        if (we_q) dirty_q[idx_q] <= 1'b1;
      end
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef PARAM_WB_CACHE_STATS_EN
  logic [31:0] hit_q, miss_q, wb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else if (state_q == S_TAG) begin
      if (hit && hit_q != '1)                     hit_q  <= hit_q + 1'b1;
      if (!hit && miss_q != '1)                   miss_q <= miss_q + 1'b1;
      if (!hit && dirty_q[idx_q] && wb_q != '1)   wb_q   <= wb_q + 1'b1;
    end
  end
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`endif
endmodule
